// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE, GNT0, GNT1)
//   - M_INST/M_DATA : master index constants (instruction port, data port)
//   - clog2() : ceiling log2, sizes the outstanding and watchdog counters
// No ports (package).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  // Number of bits needed to hold values 0 .. value-1 (minimum 1).
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    if (r == 32'sd0) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_outstanding_ctr.sv
// -----------------------------------------------------------------------------
// wb_arb_outstanding_ctr
// Counts accepted-but-unanswered Wishbone requests for the current grant.
// Saturates at MAX_OUTSTANDING and at 0; an increment and a decrement in the
// same cycle leave the count unchanged. Clear has priority over counting.
// Ports:
//   i_clk    clock (rising edge)
//   i_rst    synchronous active-high reset
//   i_inc    request accepted by the slave this cycle
//   i_dec    ack or err returned by the slave this cycle
//   i_clear  drop all outstanding requests (abort, timeout)
//   o_full   count == MAX_OUTSTANDING
//   o_empty  count == 0
// -----------------------------------------------------------------------------
module wb_arb_outstanding_ctr
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clear,
  output logic o_full,
  output logic o_empty
);

  localparam int CW = clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] r_count;

  // Saturating up/down counter of outstanding requests.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != MAX_CNT)) begin
      r_count <= r_count + ONE;
    end else if (!i_inc && i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_full  = (r_count == MAX_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
// Two-master (M0 = instruction, M1 = data), one-slave Wishbone pipelined
// arbiter. Round-robin grant from IDLE, grant held until the grantee drops
// cyc; at most MAX_OUTSTANDING requests in flight per grant.
// Optional feature: define WB_ARBITER_2M_TIMEOUT_EN to enable a response
// watchdog that errors the grantee after TIMEOUT_CYCLES without a response.
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   m0_wb_* / m1_wb_*             master-side Wishbone (cyc/stb/we/adr/dat/sel
//                                 in; stall/ack/err/dat out)
//   s_wb_*                        slave-side Wishbone
//   grant_o                       one-hot grant {M1,M0}, 00 when idle
// -----------------------------------------------------------------------------
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_stall_o,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_stall_o,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_stall_i,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_err_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  output logic [1:0]              grant_o
);

  arb_state_e r_state;
  logic       r_last_grant;
  logic [1:0] r_grant;

  logic                    w_req0, w_req1, w_gnt0, w_gnt1, w_granted;
  logic                    w_g_cyc, w_g_stb, w_g_we;
  logic [ADDR_WIDTH-1:0]   w_g_adr;
  logic [DATA_WIDTH-1:0]   w_g_dat;
  logic [DATA_WIDTH/8-1:0] w_g_sel;
  logic                    w_full, w_empty, w_timeout, w_release;
  logic                    w_ack, w_err;

  assign w_req0    = m0_wb_cyc_i & m0_wb_stb_i;
  assign w_req1    = m1_wb_cyc_i & m1_wb_stb_i;
  assign w_gnt0    = (r_state == ST_GNT0);
  assign w_gnt1    = (r_state == ST_GNT1);
  assign w_granted = w_gnt0 | w_gnt1;

  // Select the grantee's request signals; all zero while idle.
  always_comb begin
    w_g_cyc = 1'b0;
    w_g_stb = 1'b0;
    w_g_we  = 1'b0;
    w_g_adr = '0;
    w_g_dat = '0;
    w_g_sel = '0;
    case (r_state)
      ST_GNT0: begin
        w_g_cyc = m0_wb_cyc_i;
        w_g_stb = m0_wb_stb_i;
        w_g_we  = m0_wb_we_i;
        w_g_adr = m0_wb_adr_i;
        w_g_dat = m0_wb_dat_i;
        w_g_sel = m0_wb_sel_i;
      end
      ST_GNT1: begin
        w_g_cyc = m1_wb_cyc_i;
        w_g_stb = m1_wb_stb_i;
        w_g_we  = m1_wb_we_i;
        w_g_adr = m1_wb_adr_i;
        w_g_dat = m1_wb_dat_i;
        w_g_sel = m1_wb_sel_i;
      end
      default: begin
        w_g_cyc = 1'b0;
      end
    endcase
  end

  // Slave side: cyc follows the grantee so an abort drops it the same cycle;
  // stb is held off while the outstanding window is full.
  assign s_wb_cyc_o = w_g_cyc & ~w_timeout;
  assign s_wb_stb_o = w_g_cyc & w_g_stb & ~w_full & ~w_timeout;
  assign s_wb_we_o  = w_g_we;
  assign s_wb_adr_o = w_g_adr;
  assign s_wb_dat_o = w_g_dat;
  assign s_wb_sel_o = w_g_sel;

  // Responses reach the grantee only while its cycle is live, so anything
  // arriving after an abort is discarded.
  assign w_ack = w_g_cyc & s_wb_ack_i;
  assign w_err = w_g_cyc & (s_wb_err_i | w_timeout);

  assign m0_wb_ack_o   = w_gnt0 & w_ack;
  assign m0_wb_err_o   = w_gnt0 & w_err;
  assign m0_wb_dat_o   = w_gnt0 ? s_wb_dat_i : '0;
  assign m0_wb_stall_o = w_gnt0 ? (s_wb_stall_i | w_full) : 1'b1;
  assign m1_wb_ack_o   = w_gnt1 & w_ack;
  assign m1_wb_err_o   = w_gnt1 & w_err;
  assign m1_wb_dat_o   = w_gnt1 ? s_wb_dat_i : '0;
  assign m1_wb_stall_o = w_gnt1 ? (s_wb_stall_i | w_full) : 1'b1;

  // Release covers both a clean end of cycle and an abort with requests
  // still in flight; the counter is cleared either way.
  assign w_release = w_granted & (~w_g_cyc | w_timeout);

  wb_arb_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_inc   (s_wb_stb_o & ~s_wb_stall_i),
    .i_dec   (s_wb_ack_i | s_wb_err_i),
    .i_clear (w_release),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef WB_ARBITER_2M_TIMEOUT_EN
  localparam int WDW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  logic [WDW-1:0] r_wd;
  logic           w_wd_run;

  // Idle cycles (IDLE state) reset the watchdog, which covers grant changes.
  assign w_wd_run  = w_granted & ~w_empty & ~s_wb_ack_i & ~s_wb_err_i;
  assign w_timeout = w_wd_run & (r_wd == WD_LAST);

  // Response watchdog: counts silent cycles with requests in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wd <= '0;
    end else if (w_wd_run && !w_timeout) begin
      r_wd <= r_wd + WD_ONE;
    end else begin
      r_wd <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Arbiter FSM: round-robin from IDLE, grant held until release.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= M_DATA;
      r_grant      <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && (!w_req1 || (r_last_grant == M_DATA))) begin
            r_state <= ST_GNT0;
            r_grant <= 2'b01;
          end else if (w_req1) begin
            r_state <= ST_GNT1;
            r_grant <= 2'b10;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end
        end
        ST_GNT0: begin
          if (w_release) begin
            r_state      <= ST_IDLE;
            r_last_grant <= M_INST;
            r_grant      <= 2'b00;
          end else begin
            r_state <= ST_GNT0;
          end
        end
        ST_GNT1: begin
          if (w_release) begin
            r_state      <= ST_IDLE;
            r_last_grant <= M_DATA;
            r_grant      <= 2'b00;
          end else begin
            r_state <= ST_GNT1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_2m
// Directed bench for wb_arbiter_2m. The bench plays both masters and the
// slave. Expected master responses are queued when the slave response is
// driven; a negedge monitor pops and compares every ack/err it sees.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_2m;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  wire  [1:0]  m_stall, m_ack, m_err;
  wire  [31:0] m_dato [2];
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_dati;
  wire         s_cyc, s_stb, s_we;
  wire  [31:0] s_adr, s_dato;
  wire  [3:0]  s_sel;
  wire  [1:0]  grant;

  wb_arbiter_2m #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_wb_cyc_i(m_cyc[0]), .m0_wb_stb_i(m_stb[0]), .m0_wb_we_i(m_we[0]),
    .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_dat[0]), .m0_wb_sel_i(m_sel[0]),
    .m0_wb_stall_o(m_stall[0]), .m0_wb_ack_o(m_ack[0]), .m0_wb_err_o(m_err[0]),
    .m0_wb_dat_o(m_dato[0]),
    .m1_wb_cyc_i(m_cyc[1]), .m1_wb_stb_i(m_stb[1]), .m1_wb_we_i(m_we[1]),
    .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_dat[1]), .m1_wb_sel_i(m_sel[1]),
    .m1_wb_stall_o(m_stall[1]), .m1_wb_ack_o(m_ack[1]), .m1_wb_err_o(m_err[1]),
    .m1_wb_dat_o(m_dato[1]),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dato), .s_wb_sel_o(s_sel),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .s_wb_dat_i(s_dati),
    .grant_o(grant)
  );

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int m, input logic e, input logic [31:0] d);
    exp_t x;
    x.m   = 1'(m);
    x.err = e;
    x.dat = d;
    exp_q.push_back(x);
  endtask

  // Response monitor: every ack/err presented to a master must match the queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m] || m_err[m]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: master %0d ack %b err %b", m, m_ack[m], m_err[m]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_master", 32'(m), 32'(e.m));
            chk("resp_kind", {30'd0, m_ack[m], m_err[m]}, e.err ? 32'd1 : 32'd2);
            if (!e.err) begin
              chk("resp_data", m_dato[m], e.dat);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = 32'd0; m_dat[i] = 32'd0; m_sel[i] = 4'hF;
    end
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dati = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Grantee m issues back-to-back stb from an empty window: 4 accepted, then full.
  task automatic fill(input int m, input logic [31:0] base);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_adr[m] = base + 32'(i) * 32'd4;
      smp();
      chk("fill_grant", 32'(grant), (m == 1) ? 32'd2 : 32'd1);
      chk("fill_stall", 32'(m_stall[m]), 32'd0);
      chk("fill_stb", 32'(s_stb), 32'd1);
      nxt();
    end
    m_adr[m] = base + 32'd16;
    smp();
    chk("full_stall", 32'(m_stall[m]), 32'd1);
    chk("full_stb", 32'(s_stb), 32'd0);
  endtask

  // Slave returns n acks to grantee m, then m ends its cycle and releases.
  task automatic drain(input int m, input int n, input logic [31:0] d0);
    m_stb[m] = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_ack  = 1'b1;
      s_dati = d0 + 32'(i);
      push(m, 1'b0, d0 + 32'(i));
      smp();
      chk("other_stall", 32'(m_stall[1-m]), 32'd1);
      chk("other_dat", m_dato[1-m], 32'd0);
      nxt();
    end
    s_ack    = 1'b0;
    s_dati   = 32'd0;
    m_cyc[m] = 1'b0;
    smp();
    chk("release_hold", 32'(grant), (m == 1) ? 32'd2 : 32'd1);
    nxt();
    smp();
    chk("release_idle", 32'(grant), 32'd0);
    nxt();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    nxt();
    smp();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    nxt();
    rst = 1'b0;
    smp();
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_s_cyc", 32'(s_cyc), 32'd0);
    chk("idle_s_stb", 32'(s_stb), 32'd0);
    chk("idle_s_adr", s_adr, 32'd0);
    chk("idle_stall", 32'(m_stall), 32'd3);
    nxt();

    // Single M0 read of 0x0001_0000.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0001_0000;
    smp();
    chk("t1_grant_req_cycle", 32'(grant), 32'd0);
    chk("t1_stall_req_cycle", 32'(m_stall[0]), 32'd1);
    nxt();
    smp();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_s_stb", 32'(s_stb), 32'd1);
    chk("t1_s_adr", s_adr, 32'h0001_0000);
    chk("t1_m0_stall", 32'(m_stall[0]), 32'd0);
    chk("t1_m1_stall", 32'(m_stall[1]), 32'd1);
    nxt();
    drain(0, 1, 32'hCAFE_0001);

    // Both masters request on the first cycle after reset.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr[0] = 32'h0000_0100; m_adr[1] = 32'h0000_0200;
    m_we[1] = 1'b1; m_dat[1] = 32'h1234_5678; m_sel[1] = 4'h3;
    smp();
    nxt();
    smp();
    chk("t2_first_m0", 32'(grant), 32'd1);
    chk("t2_adr_m0", s_adr, 32'h0000_0100);
    chk("t2_we_m0", 32'(s_we), 32'd0);
    chk("t2_m1_waits", 32'(m_stall[1]), 32'd1);
    nxt();
    m_stb[0] = 1'b0; s_ack = 1'b1; s_dati = 32'h0000_00A0;
    push(0, 1'b0, 32'h0000_00A0);
    smp();
    chk("t2_m1_noack", 32'(m_ack[1]), 32'd0);
    nxt();
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    smp();
    nxt();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    smp();
    chk("t2_idle_gap", 32'(grant), 32'd0);
    nxt();
    smp();
    chk("t2_rr_m1", 32'(grant), 32'd2);
    chk("t2_adr_m1", s_adr, 32'h0000_0200);
    chk("t2_we_m1", 32'(s_we), 32'd1);
    chk("t2_dat_m1", s_dato, 32'h1234_5678);
    chk("t2_sel_m1", 32'(s_sel), 32'd3);
    chk("t2_m0_waits", 32'(m_stall[0]), 32'd1);
    nxt();
    m_we[1] = 1'b0;
    drain(1, 1, 32'h0000_00B1);
    smp();
    chk("t2_m0_after", 32'(grant), 32'd1);
    nxt();
    drain(0, 1, 32'h0000_00A2);

    // M1 six back-to-back stb with acks held off.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_3000;
    smp();
    nxt();
    fill(1, 32'h0000_3000);
    nxt();
    smp();
    chk("t3_still_full", 32'(s_stb), 32'd0);
    nxt();
    s_ack = 1'b1; s_dati = 32'h0000_0D00;
    push(1, 1'b0, 32'h0000_0D00);
    smp();
    chk("t3_full_on_ack", 32'(m_stall[1]), 32'd1);
    nxt();
    s_ack = 1'b0;
    smp();
    chk("t3_resume_stall", 32'(m_stall[1]), 32'd0);
    chk("t3_resume_stb", 32'(s_stb), 32'd1);
    nxt();
    s_ack = 1'b1; s_dati = 32'h0000_0D01;
    push(1, 1'b0, 32'h0000_0D01);
    smp();
    chk("t3_full_again", 32'(m_stall[1]), 32'd1);
    nxt();
    s_ack = 1'b0;
    smp();
    chk("t3_sixth_stb", 32'(s_stb), 32'd1);
    nxt();
    drain(1, 4, 32'h0000_0D02);

    // Abort: M1 drops cyc with 2 outstanding, late acks are discarded.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    smp();
    nxt();
    smp();
    chk("t4_grant", 32'(grant), 32'd2);
    nxt();
    smp();
    nxt();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b1; s_dati = 32'hDEAD_0001;
    smp();
    chk("t4_cyc_drop", 32'(s_cyc), 32'd0);
    chk("t4_no_ack", 32'(m_ack[1]), 32'd0);
    nxt();
    smp();
    chk("t4_idle", 32'(grant), 32'd0);
    chk("t4_late_ack", 32'(m_ack), 32'd0);
    nxt();
    s_ack = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    smp();
    nxt();
    fill(1, 32'h0000_4000);
    nxt();
    drain(1, 4, 32'h0000_0E00);

    // Reset mid-burst.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    smp();
    nxt();
    smp();
    nxt();
    smp();
    nxt();
    m_stb[1] = 1'b0; rst = 1'b1;
    smp();
    nxt();
    s_ack = 1'b1; s_dati = 32'hDEAD_0002;
    smp();
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_s_cyc", 32'(s_cyc), 32'd0);
    chk("t5_no_resp", 32'(m_ack), 32'd0);
    nxt();
    rst = 1'b0; s_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    smp();
    nxt();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    fill(0, 32'h0000_5000);
    nxt();
    drain(0, 4, 32'h0000_0F00);

`ifdef WB_ARBITER_2M_TIMEOUT_EN
    // Slave never answers: watchdog errors M0 eight cycles after acceptance.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    smp();
    nxt();
    smp();
    chk("t6_grant", 32'(grant), 32'd1);
    nxt();
    m_stb[0] = 1'b0;
    for (int k = 1; k < 8; k++) begin
      smp();
      chk("t6_no_err", 32'(m_err[0]), 32'd0);
      chk("t6_cyc_held", 32'(s_cyc), 32'd1);
      nxt();
    end
    push(0, 1'b1, 32'd0);
    smp();
    chk("t6_err_pulse", 32'(m_err[0]), 32'd1);
    chk("t6_cyc_forced", 32'(s_cyc), 32'd0);
    nxt();
    smp();
    chk("t6_err_once", 32'(m_err[0]), 32'd0);
    chk("t6_idle", 32'(grant), 32'd0);
    m_cyc[0] = 1'b0;
    nxt();
`endif

    smp();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
